// File: rtl/regfile_mp_bypass.sv
// Multi-read-port register file with byte-lane writes, optional same-cycle
// write-to-read forwarding and a self-sequencing clear/preset pass after reset.
module regfile_mp_bypass #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_COUNT  = 32,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 1,
   parameter int PRESET_A0  = 5,
   parameter logic [DATA_WIDTH-1:0] PRESET_V0 = 6,
   parameter int PRESET_A1  = 9,
   parameter logic [DATA_WIDTH-1:0] PRESET_V1 = 'h2004
) (
   input  logic                         CLK,
   input  logic                         rst_n,
   input  logic                         WE3,
   input  logic [ADDR_WIDTH-1:0]        A3,
   input  logic [DATA_WIDTH-1:0]        WD3,
   input  logic [DATA_WIDTH/8-1:0]      BE3,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] RA,
   output logic [NUM_RD*DATA_WIDTH-1:0] RD,
   input  logic                         clr_req,
   output logic                         ready
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REG_COUNT - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   cnt;
   logic [DATA_WIDTH-1:0]   mem [REG_COUNT];
   logic                    wr_en;
   logic                    fwd_en;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return (32'(a) < 32'(REG_COUNT));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                   input logic [DATA_WIDTH-1:0] new_v,
                                                   input logic [NBYTES-1:0]     be);
      logic [DATA_WIDTH-1:0] r;
      r = old_v;
      for (int b = 0; b < NBYTES; b++) begin
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] clear_value(input logic [ADDR_WIDTH-1:0] a);
      if (a == ADDR_WIDTH'(PRESET_A0)) return PRESET_V0;
      if (a == ADDR_WIDTH'(PRESET_A1)) return PRESET_V1;
      return '0;
   endfunction

   // A clear request wins over a coincident write; register 0 is never written.
   assign wr_en  = WE3 && !clr_req && (A3 != '0) && in_range(A3);
   assign fwd_en = (BYPASS != 0) && ready && WE3 && (A3 != '0) && in_range(A3);

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= READY;
                  ready <= 1'b1;
               end
            end
            READY: begin
               if (clr_req) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  ready <= 1'b0;
               end
            end
            default: begin
               state <= CLEAR;
               cnt   <= '0;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // Array has no reset; contents are defined by the clear pass.
   always_ff @(posedge CLK) begin
      if (rst_n) begin
         if (state == CLEAR) begin
            mem[cnt] <= clear_value(cnt);
         end else if (wr_en) begin
            mem[A3] <= merge(mem[A3], WD3, BE3);
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;

      assign addr = RA[k*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         data = '0;
         if ((addr != '0) && in_range(addr)) begin
            if (fwd_en && (addr == A3)) data = merge(mem[addr], WD3, BE3);
            else                        data = mem[addr];
         end
      end

      assign RD[k*DATA_WIDTH +: DATA_WIDTH] = data;
   end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Scoreboard bench for regfile_mp_bypass: a bypassing 2-port instance and a
// non-bypassing 3-port instance, directed vectors with hand-computed results.
module tb_regfile_mp_bypass;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic        a_we, a_clr;
   logic [4:0]  a_a3;
   logic [31:0] a_wd;
   logic [3:0]  a_be;
   logic [9:0]  a_ra;
   logic [63:0] a_rd;
   logic        a_ready;

   logic        b_we, b_clr;
   logic [4:0]  b_a3;
   logic [31:0] b_wd;
   logic [3:0]  b_be;
   logic [14:0] b_ra;
   logic [95:0] b_rd;
   logic        b_ready;

   typedef struct {
      int          kind;   // 0: A.RD  1: A.ready  2: B.RD  3: B.ready
      int          port;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 CLK = ~CLK;

   regfile_mp_bypass dut_a (
      .CLK(CLK), .rst_n(rst_n), .WE3(a_we), .A3(a_a3), .WD3(a_wd), .BE3(a_be),
      .RA(a_ra), .RD(a_rd), .clr_req(a_clr), .ready(a_ready)
   );

   regfile_mp_bypass #(.NUM_RD(3), .BYPASS(0)) dut_b (
      .CLK(CLK), .rst_n(rst_n), .WE3(b_we), .A3(b_a3), .WD3(b_wd), .BE3(b_be),
      .RA(b_ra), .RD(b_rd), .clr_req(b_clr), .ready(b_ready)
   );

   // Monitor: drains every expectation queued during the current cycle.
   always @(negedge CLK) begin
      while (q.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e = q.pop_front();
         case (e.kind)
            0:       act = a_rd[e.port*32 +: 32];
            1:       act = {31'b0, a_ready};
            2:       act = b_rd[e.port*32 +: 32];
            default: act = {31'b0, b_ready};
         endcase
         n_chk++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic expect_v(input int kind, input int port, input logic [31:0] v, input string name);
      exp_t e;
      e.kind = kind; e.port = port; e.val = v; e.name = name;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ready_run(input string name, input bit with_b);
      for (int k = 1; k <= 32; k++) begin
         tick();
         expect_v(1, 0, (k == 32) ? 32'd1 : 32'd0, name);
         if (with_b && k == 32) expect_v(3, 0, 32'd1, {name, "_b"});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a_we = 0; a_clr = 0; a_a3 = 0; a_wd = 0; a_be = 0; a_ra = 0;
      b_we = 0; b_clr = 0; b_a3 = 0; b_wd = 0; b_be = 0; b_ra = 0;

      tick();
      expect_v(1, 0, 32'd0, "reset_ready_a");
      expect_v(3, 0, 32'd0, "reset_ready_b");
      tick();
      rst_n = 1'b1;
      ready_run("init_ready", 1'b1);

      // Presets after clear
      a_ra = {5'd9, 5'd5};
      expect_v(0, 0, 32'd6,         "preset_r5");
      expect_v(0, 1, 32'h0000_2004, "preset_r9");
      tick();
      a_ra = {5'd9, 5'd7};
      expect_v(0, 0, 32'd0, "cleared_r7");
      tick();

      // Non-bypassing 3-port instance
      b_we = 1; b_a3 = 6; b_wd = 32'h1; b_be = 4'hF;
      tick();
      b_wd = 32'h2; b_ra = {5'd6, 5'd6, 5'd6};
      for (int p = 0; p < 3; p++) expect_v(2, p, 32'h1, "nobyp_write_cycle");
      tick();
      b_we = 0;
      for (int p = 0; p < 3; p++) expect_v(2, p, 32'h2, "nobyp_after_edge");
      tick();

      // Full-word write with forwarding on both ports
      a_we = 1; a_a3 = 3; a_wd = 32'hDEAD_BEEF; a_be = 4'hF; a_ra = {5'd3, 5'd3};
      expect_v(0, 0, 32'hDEAD_BEEF, "byp_full_p0");
      expect_v(0, 1, 32'hDEAD_BEEF, "byp_full_p1");
      tick();
      a_we = 0;
      expect_v(0, 0, 32'hDEAD_BEEF, "stored_full");
      tick();

      // Byte-lane merge
      a_we = 1; a_wd = 32'h1122_3344; a_be = 4'b0101; a_ra = {5'd5, 5'd3};
      expect_v(0, 0, 32'hDE22_BE44, "byp_lanes");
      expect_v(0, 1, 32'd6,         "indep_port1");
      tick();
      a_we = 0;
      expect_v(0, 0, 32'hDE22_BE44, "stored_lanes");
      tick();
      a_we = 1; a_wd = 32'h0; a_be = 4'h0;
      expect_v(0, 0, 32'hDE22_BE44, "byp_no_lanes");
      tick();
      a_we = 0;
      expect_v(0, 0, 32'hDE22_BE44, "stored_no_lanes");
      tick();

      // Register 0 is hardwired
      a_we = 1; a_a3 = 0; a_wd = 32'hFFFF_FFFF; a_be = 4'hF; a_ra = {5'd0, 5'd0};
      expect_v(0, 0, 32'd0, "r0_write_cycle_p0");
      expect_v(0, 1, 32'd0, "r0_write_cycle_p1");
      tick();
      a_we = 0;
      expect_v(0, 0, 32'd0, "r0_after_p0");
      expect_v(0, 1, 32'd0, "r0_after_p1");
      tick();

      // Clear request discards a coincident write
      a_we = 1; a_a3 = 4; a_wd = 32'hCAFE_F00D; a_be = 4'hF;
      tick();
      a_ra = {5'd3, 5'd4};
      a_wd = 32'h1234_5678; a_clr = 1;
      tick();
      a_we = 0; a_clr = 0;
      expect_v(1, 0, 32'd0, "clr_ready_drop");
      ready_run("clr_ready", 1'b0);
      expect_v(0, 0, 32'd0, "clr_r4_lost");
      expect_v(0, 1, 32'd0, "clr_r3_cleared");
      tick();

      // Reset in the middle of a clear pass restarts the count
      a_clr = 1;
      tick();
      a_clr = 0;
      for (int k = 0; k < 10; k++) tick();
      rst_n = 0;
      tick();
      expect_v(1, 0, 32'd0, "midclr_reset_ready");
      rst_n = 1;
      ready_run("midclr_ready", 1'b1);
      a_ra = {5'd9, 5'd5};
      expect_v(0, 0, 32'd6,         "midclr_r5");
      expect_v(0, 1, 32'h0000_2004, "midclr_r9");
      tick();

      @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
